// File: rtl/iotdf_pkg.sv
// Shared widths, function codes and FSM states for the IoT data filter sequencer.
package iotdf_pkg;

  localparam int WORD_W         = 128;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 16;

  typedef enum logic [2:0] {
    FN_NONE = 3'd0,
    FN_MAX  = 3'd1,
    FN_MIN  = 3'd2,
    FN_AVG  = 3'd3,
    FN_EXT  = 3'd4,
    FN_EXC  = 3'd5
  } fn_e;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  // Codes outside 1..5 select no unit at all.
  function automatic logic [4:0] fn_onehot(input logic [2:0] fn);
    logic [4:0] oh;
    oh = '0;
    case (fn)
      FN_MAX:  oh = 5'b00001;
      FN_MIN:  oh = 5'b00010;
      FN_AVG:  oh = 5'b00100;
      FN_EXT:  oh = 5'b01000;
      FN_EXC:  oh = 5'b10000;
      default: oh = 5'b00000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/iotdf_word_asm.sv
// Byte-to-word assembler: shifts sensor bytes MSB-first and loads the held data word on byte 16.
module iotdf_word_asm
  import iotdf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              load_o,
  output logic [WORD_W-1:0] data_word_o
);

  logic [WORD_W-BYTE_W-1:0] sh_q;
  logic [3:0]               byte_cnt_q;
  logic [WORD_W-1:0]        data_word_q;

  assign load_o      = accept_i && (byte_cnt_q == 4'(BYTES_PER_WORD - 1));
  assign data_word_o = data_word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q        <= '0;
      byte_cnt_q  <= '0;
      data_word_q <= '0;
    end else begin
      if (accept_i) begin
        sh_q       <= {sh_q[WORD_W-2*BYTE_W-1:0], byte_i};
        byte_cnt_q <= byte_cnt_q + 4'd1;
      end
      if (load_o) begin
        data_word_q <= {sh_q, byte_i};
      end
    end
  end

endmodule

// File: rtl/iotdf_ctrl.sv
// IoT data filter sequencer: run FSM, phase counter, unit enables and result capture.
// Optional IOTDF_RESULT_CNT_EN adds result_cnt and delays done until the final result is counted.
module iotdf_ctrl
  import iotdf_pkg::*;
#(
  parameter int NUM_WORDS = 96,
  parameter int ROUND_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_en,
  input  logic [BYTE_W-1:0] iot_in,
  input  logic [2:0]        fn_sel,
  output logic              busy,
  output logic              valid,
  output logic [WORD_W-1:0] iot_out,
  output logic              done,
  output logic [WORD_W-1:0] data_word,
  output logic [3:0]        cnt_cycle,
  output logic              round_last,
  output logic [4:0]        fu_en,
`ifdef IOTDF_RESULT_CNT_EN
  output logic [6:0]        result_cnt,
`endif
  input  logic              flt_vld,
  input  logic [WORD_W-1:0] flt_res
);

  localparam int IDX_W = (ROUND_LEN > 1) ? $clog2(ROUND_LEN) : 1;
  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  state_e            state_q;
  logic [2:0]        fn_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [3:0]        cnt_cycle_q;
  logic              round_last_q, busy_q, valid_q, done_q;
  logic [4:0]        fu_en_q;
  logic [WORD_W-1:0] iot_out_q;
  logic              accept, load, capture, last_load;

  assign accept    = in_en && !busy_q;
  assign capture   = (cnt_cycle_q == 4'd1) && flt_vld && (fu_en_q != 5'd0);
  assign last_load = load && (word_cnt_q == CNT_W'(NUM_WORDS - 1));

  iotdf_word_asm u_word_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_i    (accept),
    .byte_i      (iot_in),
    .load_o      (load),
    .data_word_o (data_word)
  );

  always_comb begin
    word_idx_d = word_idx_q + IDX_W'(1);
    if (word_cnt_q == '0 || word_idx_q == IDX_W'(ROUND_LEN - 1)) begin
      word_idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fn_q         <= '0;
      word_cnt_q   <= '0;
      word_idx_q   <= '0;
      cnt_cycle_q  <= '0;
      round_last_q <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      fu_en_q      <= '0;
      iot_out_q    <= '0;
    end else begin
      // A load restarts the phase; otherwise a running phase free-runs and parks at 0.
      if (load) begin
        cnt_cycle_q  <= 4'd1;
        word_idx_q   <= word_idx_d;
        round_last_q <= (word_idx_d == IDX_W'(ROUND_LEN - 1));
        word_cnt_q   <= word_cnt_q + CNT_W'(1);
      end else if (cnt_cycle_q != 4'd0) begin
        cnt_cycle_q <= cnt_cycle_q + 4'd1;
      end

      valid_q <= capture;
      if (capture) begin
        iot_out_q <= flt_res;
      end

      case (state_q)
        IDLE: if (accept) begin
          state_q <= LOAD;
          fn_q    <= fn_sel;
          fu_en_q <= fn_onehot(fn_sel);
        end
        LOAD: if (last_load) begin
          state_q <= DRAIN;
          busy_q  <= 1'b1;
        end
        DRAIN: if (cnt_cycle_q == 4'd1) begin
          state_q <= DONE;
          fu_en_q <= '0;
`ifdef IOTDF_RESULT_CNT_EN
          done_q  <= !capture;
`else
          done_q  <= 1'b1;
`endif
        end
        DONE: done_q <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IOTDF_RESULT_CNT_EN
  logic [6:0] result_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_cnt_q <= '0;
    end else if (valid_q && result_cnt_q != 7'd127) begin
      result_cnt_q <= result_cnt_q + 7'd1;
    end
  end

  assign result_cnt = result_cnt_q;
`endif

  assign busy       = busy_q;
  assign valid      = valid_q;
  assign iot_out    = iot_out_q;
  assign done       = done_q;
  assign cnt_cycle  = cnt_cycle_q;
  assign round_last = round_last_q;
  assign fu_en      = fu_en_q;

endmodule
